// File: rtl/acc_cpu_pkg.sv
// rtl/acc_cpu_pkg.sv - opcode, state and width constants shared by the acc_cpu files
package acc_cpu_pkg;

   localparam int OP_W = 4;

   localparam logic [OP_W-1:0] OP_NOP  = 4'd0;
   localparam logic [OP_W-1:0] OP_LDI  = 4'd1;
   localparam logic [OP_W-1:0] OP_LDX  = 4'd2;
   localparam logic [OP_W-1:0] OP_ADD  = 4'd3;
   localparam logic [OP_W-1:0] OP_SUB  = 4'd4;
   localparam logic [OP_W-1:0] OP_AND  = 4'd5;
   localparam logic [OP_W-1:0] OP_OR   = 4'd6;
   localparam logic [OP_W-1:0] OP_XOR  = 4'd7;
   localparam logic [OP_W-1:0] OP_ADDI = 4'd8;
   localparam logic [OP_W-1:0] OP_JMP  = 4'd9;
   localparam logic [OP_W-1:0] OP_JC   = 4'd10;
   localparam logic [OP_W-1:0] OP_JZ   = 4'd11;
   localparam logic [OP_W-1:0] OP_HLT  = 4'd12;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

endpackage

// File: rtl/acc_cpu_alu.sv
// rtl/acc_cpu_alu.sv - combinational ALU: accumulator result plus carry/zero update strobes
module acc_cpu_alu
   import acc_cpu_pkg::*;
#(
   parameter int DATA_W = 4
)(
   input  logic [OP_W-1:0]   i_op,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic [DATA_W-1:0] i_imm,
   output logic [DATA_W-1:0] o_result,
   output logic              o_carry,
   output logic              o_carry_upd,
   output logic              o_zero_upd
);

   logic [DATA_W:0] w_sum;

   // Opcode decode; ops that do not write the accumulator pass i_a through.
   // LDX only raises the zero strobe here, its operand is selected in the top.
   always_comb begin
      w_sum       = '0;
      o_result    = i_a;
      o_carry     = 1'b0;
      o_carry_upd = 1'b0;
      o_zero_upd  = 1'b0;
      case (i_op)
         OP_NOP: ;
         OP_LDI: begin
            o_result   = i_imm;
            o_zero_upd = 1'b1;
         end
         OP_LDX: o_zero_upd = 1'b1;
         OP_ADD: begin
            w_sum       = {1'b0, i_a} + {1'b0, i_b};
            o_result    = w_sum[DATA_W-1:0];
            o_carry     = w_sum[DATA_W];
            o_carry_upd = 1'b1;
            o_zero_upd  = 1'b1;
         end
         OP_SUB: begin
            // the extra top bit of a widened subtraction is the borrow
            w_sum       = {1'b0, i_a} - {1'b0, i_b};
            o_result    = w_sum[DATA_W-1:0];
            o_carry     = w_sum[DATA_W];
            o_carry_upd = 1'b1;
            o_zero_upd  = 1'b1;
         end
         OP_AND: begin
            o_result   = i_a & i_b;
            o_zero_upd = 1'b1;
         end
         OP_OR: begin
            o_result   = i_a | i_b;
            o_zero_upd = 1'b1;
         end
         OP_XOR: begin
            o_result   = i_a ^ i_b;
            o_zero_upd = 1'b1;
         end
         OP_ADDI: begin
            w_sum       = {1'b0, i_a} + {1'b0, i_imm};
            o_result    = w_sum[DATA_W-1:0];
            o_carry     = w_sum[DATA_W];
            o_carry_upd = 1'b1;
            o_zero_upd  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/acc_cpu.sv
// rtl/acc_cpu.sv - accumulator CPU top (FSM, pc, program memory, acc, flags); optional ACC_CPU_STEP_EN
module acc_cpu
   import acc_cpu_pkg::*;
#(
   parameter  int DATA_W  = 4,
   parameter  int PC_W    = 3,
   localparam int INSTR_W = OP_W + DATA_W
)(
   input  logic               clk,
   input  logic               rstn,
   input  logic               start,
`ifdef ACC_CPU_STEP_EN
   input  logic               step_mode,
   input  logic               step,
`endif
   input  logic               prog_we,
   input  logic [PC_W-1:0]    prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   input  logic [DATA_W-1:0]  ext_in,
   input  logic [DATA_W-1:0]  alu_in,
   output logic [DATA_W-1:0]  acc_out,
   output logic [PC_W-1:0]    pc_out,
   output logic [INSTR_W-1:0] instr_out,
   output logic               carry_out,
   output logic               zero_out,
   output logic               running,
   output logic               halted
);

   localparam int DEPTH = 2**PC_W;

   logic [1:0]         r_state;
   logic [PC_W-1:0]    r_pc;
   logic [DATA_W-1:0]  r_acc;
   logic               r_carry;
   logic               r_zero;
   logic [INSTR_W-1:0] r_mem [DEPTH];

   logic [OP_W-1:0]    w_op;
   logic [DATA_W-1:0]  w_imm;
   logic [DATA_W-1:0]  w_alu_res;
   logic [DATA_W-1:0]  w_acc_nxt;
   logic               w_alu_c;
   logic               w_c_upd;
   logic               w_z_upd;
   logic               w_exec;
   logic               w_take;
   logic [PC_W-1:0]    w_pc_nxt;

   assign instr_out = r_mem[r_pc];
   assign w_op      = instr_out[INSTR_W-1 -: OP_W];
   assign w_imm     = instr_out[DATA_W-1:0];

`ifdef ACC_CPU_STEP_EN
   assign w_exec = (r_state == ST_RUN) && (!step_mode || step);
`else
   assign w_exec = (r_state == ST_RUN);
`endif

   acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .i_op        (w_op),
      .i_a         (r_acc),
      .i_b         (alu_in),
      .i_imm       (w_imm),
      .o_result    (w_alu_res),
      .o_carry     (w_alu_c),
      .o_carry_upd (w_c_upd),
      .o_zero_upd  (w_z_upd)
   );

   assign w_acc_nxt = (w_op == OP_LDX) ? ext_in : w_alu_res;

   // Branch condition for the instruction at pc
   always_comb begin
      w_take = 1'b0;
      case (w_op)
         OP_JMP:  w_take = 1'b1;
         OP_JC:   w_take = r_carry;
         OP_JZ:   w_take = r_zero;
         default: w_take = 1'b0;
      endcase
   end

   // Next pc: HLT parks on its own address, taken jumps load the immediate
   always_comb begin
      w_pc_nxt = r_pc + 1'b1;
      if (w_op == OP_HLT)
         w_pc_nxt = r_pc;
      else if (w_take)
         w_pc_nxt = w_imm[PC_W-1:0];
   end

   // Control FSM with pc, accumulator and flag updates
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
         r_pc    <= '0;
         r_acc   <= '0;
         r_carry <= 1'b0;
         r_zero  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_pc <= '0;
               if (start)
                  r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (w_exec) begin
                  r_pc  <= w_pc_nxt;
                  r_acc <= w_acc_nxt;
                  if (w_c_upd)
                     r_carry <= w_alu_c;
                  if (w_z_upd)
                     r_zero <= (w_acc_nxt == '0);
                  if (w_op == OP_HLT)
                     r_state <= ST_HALT;
               end
            end
            ST_HALT: begin
               if (start) begin
                  r_state <= ST_IDLE;
                  r_pc    <= '0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Program store: not reset, and locked while the core executes
   always_ff @(posedge clk) begin
      if (prog_we && (r_state != ST_RUN))
         r_mem[prog_addr] <= prog_data;
   end

   assign acc_out   = r_acc;
   assign pc_out    = r_pc;
   assign carry_out = r_carry;
   assign zero_out  = r_zero;
   assign running   = (r_state == ST_RUN);
   assign halted    = (r_state == ST_HALT);

endmodule

// File: doc/acc_cpu.md
Name: acc_cpu

Overview:
- Parametrised accumulator CPU: next generation of the fixed 4-bit, 8-step control-ROM datapath.
- Adds a writable program memory, an immediate operand field, carry/zero flags, jumps, and a start/halt state machine.
- Sits at the top of cpu_controller, and is observed from the pads in the same way as the existing cpu.

Parameters:
- DATA_W, 4, accumulator / operand / immediate width (>= PC_W).
- PC_W, 3, program counter width; program depth = 2**PC_W.
- INSTR_W, 4+DATA_W, instruction width = {op[3:0], imm[DATA_W-1:0]}; derived, not overridable.

Ports:
- clk  in  1  clock; all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  level; sampled in IDLE/HALT.
- prog_we  in  1  program-memory write enable.
- prog_addr  in  PC_W  write address.
- prog_data  in  INSTR_W  write data.
- ext_in  in  DATA_W  external load operand (LDX).
- alu_in  in  DATA_W  external ALU B operand.
- acc_out  out  DATA_W  accumulator.
- pc_out  out  PC_W  program counter.
- instr_out  out  INSTR_W  instruction currently at pc.
- carry_out  out  1  carry flag.
- zero_out  out  1  zero flag.
- running  out  1  state==RUN.
- halted  out  1  state==HALT.

Behaviour:
- Reset (async, rstn low):
  - state=IDLE; pc=0; acc=0; carry=0; zero=0.
  - Program memory is NOT reset; contents are undefined until written.
- States:
  - IDLE: pc held at 0. start=1 -> RUN.
  - RUN: one instruction per cycle. HLT -> HALT.
  - HALT: pc/acc/flags frozen. start=1 -> IDLE, which clears pc to 0; acc and flags are kept.
  - start is ignored in RUN.
- Fetch: instr_out = mem[pc], read combinationally. The instruction executes at the next clock edge, so results are visible 1 cycle after the instruction appears.
- Program write: mem[prog_addr] <= prog_data on an edge where prog_we=1 and state != RUN. Writes in RUN are dropped.
- Write and start on the same edge: the write lands, and the first RUN fetch sees the new value.
- Opcodes (op field); imm = low DATA_W bits:
  - 0 NOP.
  - 1 LDI: acc=imm.
  - 2 LDX: acc=ext_in.
  - 3 ADD: acc=acc+alu_in.
  - 4 SUB: acc=acc-alu_in.
  - 5 AND, 6 OR, 7 XOR: with alu_in.
  - 8 ADDI: acc=acc+imm.
  - 9 JMP: pc=imm[PC_W-1:0].
  - 10 JC: jump if carry.
  - 11 JZ: jump if zero.
  - 12 HLT.
  - 13-15: treated as NOP.
- Arithmetic: results truncated to DATA_W.
  - carry = bit DATA_W of the (DATA_W+1)-bit result for ADD/ADDI.
  - For SUB, carry = borrow (1 when acc < alu_in).
  - carry is updated only by ADD, SUB and ADDI.
- zero = (new acc==0). Updated by LDI, LDX, ADD, SUB, AND, OR, XOR, ADDI. Jumps, NOP and HLT leave both flags unchanged.
- PC: pc+1 wrapping from 2**PC_W-1 to 0, unless a jump is taken. A taken jump to the current address loops. HLT leaves pc at the HLT address.
- Reset mid-RUN: immediate return to the reset values; the program memory is retained.

Optional Feature:
- Macro: ACC_CPU_STEP_EN.
- When defined: adds input step_mode (1) and input step (1).
  - With step_mode=1, RUN executes an instruction only on edges where step=1; otherwise all state holds.
  - step_mode=0 behaves as free-run.
  - start is not affected.
- When undefined: the ports are absent and RUN free-runs every cycle.

Decomposition:
- Package acc_cpu_pkg:
  - Opcode constants (OP_NOP..OP_HLT, 4-bit).
  - State encoding (ST_IDLE=0, ST_RUN=1, ST_HALT=2, 2-bit).
  - OP_W=4.
- Sub-module acc_cpu_alu: combinational. Takes op, a, b, imm; produces result, carry, carry_upd, zero_upd.
- Top acc_cpu holds the FSM, pc, program memory, acc and flags.

Test Plan:
- Reset/idle: assert rstn=0 mid-RUN -> acc_out=0, pc_out=0, carry_out=0, zero_out=0, running=0 immediately, without waiting for a clock.
- Immediate arithmetic: program {LDI 9, ADDI 8, HLT}, start -> acc=9, then acc=1 with carry=1 and zero=0, then halted=1 with pc_out=2 held.
- External ops: alu_in=3, program {LDX, SUB, HLT}, ext_in=3 -> acc=3, then acc=0 with zero=1 and carry=0. Repeat with ext_in=2 -> acc=15, carry=1.
- Branching: program {LDI 15, ADDI 1, JC 5, NOP, NOP, HLT} -> pc sequence 0,1,2,5. JZ at 2 is also taken (zero=1). Rerun with JZ after LDI 1 -> not taken, pc 3.
- Wrap/write-protect: program of 8 NOPs runs pc 7->0. prog_we during RUN does not change mem (read back after HLT). Write plus start on the same edge executes the new word at address 0.
- Step (ACC_CPU_STEP_EN): step_mode=1, step pulsed every 3rd cycle -> pc advances only on pulse edges; acc stable between pulses.
